// File: rtl/dram_ar_arbiter.sv
// Read-address arbiter sharing the DRAM controller AR port between cache requesters.
// Fixed priority with starvation override, registered AR, in-flight read limit.
module dram_ar_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int STARVE_LIMIT    = 16,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_arvalid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr_i,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   req_arid_i,
    output logic [NUM_REQ-1:0]            req_arready_o,
    output logic [ID_WIDTH-1:0]           arid_o,
    output logic [ADDR_WIDTH-1:0]         araddr_o,
    output logic                          arvalid_o,
    input  logic                          arready_i,
    input  logic                          rvalid_i,
    input  logic                          rready_i,
    input  logic                          rlast_i,
    output logic [GW-1:0]                 grant_o,
    output logic [7:0]                    outstanding_o
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [7:0]              wait_cnt [NUM_REQ];
    logic [7:0]              outstanding;
    logic [GW-1:0]           winner;
    logic                    found_starved;
    logic                    found_valid;
    logic                    pick;
    logic                    ar_hs;
    logic                    r_done;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [ID_WIDTH-1:0]     sel_id;

    assign ar_hs         = arvalid_o & arready_i;
    assign r_done        = rvalid_i & rready_i & rlast_i;
    assign outstanding_o = outstanding;

    // A starved requester beats plain priority; lowest index wins within each class.
    always_comb begin
        winner        = '0;
        found_starved = 1'b0;
        found_valid   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_starved && req_arvalid_i[k] &&
                wait_cnt[k] == 8'(STARVE_LIMIT)) begin
                winner        = GW'(k);
                found_starved = 1'b1;
            end
        end
        if (!found_starved) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found_valid && req_arvalid_i[k]) begin
                    winner      = GW'(k);
                    found_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == GW'(k)) begin
                sel_addr = req_araddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_id   = req_arid_i[k*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    // Gated by rst_n so no accept pulse escapes while reset is held.
    assign pick = rst_n && (state == S_IDLE) && (|req_arvalid_i) &&
                  (outstanding < 8'(MAX_OUTSTANDING));

    assign req_arready_o = pick ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (pick)      state_nxt = S_ISSUE;
            S_ISSUE: if (arready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            arvalid_o <= 1'b0;
            araddr_o  <= '0;
            arid_o    <= '0;
            grant_o   <= '0;
        end else begin
            state <= state_nxt;
            if (pick) begin
                arvalid_o <= 1'b1;
                araddr_o  <= sel_addr;
                arid_o    <= sel_id;
                grant_o   <= winner;
            end else if (ar_hs) begin
                arvalid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) wait_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_arvalid_i[k] || req_arready_o[k])
                    wait_cnt[k] <= '0;
                else if (wait_cnt[k] != 8'(STARVE_LIMIT))
                    wait_cnt[k] <= wait_cnt[k] + 8'd1;
            end
        end
    end

    // Simultaneous issue and retire leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            unique case ({ar_hs, r_done})
                2'b10:   outstanding <= outstanding + 8'd1;
                2'b01:   if (outstanding != 8'd0) outstanding <= outstanding - 8'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (r_done && !ar_hs) |-> (outstanding != 8'd0));

endmodule
